vga_timing_gen: RTL

VGA raster timing generator and pixel output stage for the 640x480 display path. It produces the per-pixel draw coordinates that the color mapper consumes, then samples the mapper's combinational RGB back in. It drives blanked, registered RGB together with aligned hsync/vsync to the DAC, and emits a once-per-frame tick that game logic uses to update ship, enemy and bullet positions during vertical blank.

---
 rtl/vga_timing_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Summary  : VGA raster counters, blanked/registered RGB, sync and frame tick.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [9:0] draw_xpos_o,
    output logic [9:0] draw_ypos_o,
    input  logic [7:0] red_i,
    input  logic [7:0] green_i,
    input  logic [7:0] blue_i,
    output logic [7:0] red_o,
    output logic [7:0] green_o,
    output logic [7:0] blue_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       blank_o,
    output logic       pix_en_o,
    output logic       frame_tick_o
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (c_H_TOTAL > 1024 || c_V_TOTAL > 1024) begin : g_bad_totals
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must lie in 1..8");
        end
    endgenerate

    localparam logic [2:0]  c_DIV_LAST = 3'(CLK_DIV - 1);
    localparam logic [9:0]  c_H_LAST   = 10'(c_H_TOTAL - 1);
    localparam logic [9:0]  c_V_LAST   = 10'(c_V_TOTAL - 1);
    localparam logic [9:0]  c_V_TICK   = 10'(V_VISIBLE - 1);
    // 11-bit bounds so a sync window ending exactly at 1024 does not wrap
    localparam logic [10:0] c_H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] c_HS_BEG   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] c_V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] c_VS_BEG   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] c_VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [2:0] r_div;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic [7:0] r_red;
    logic [7:0] r_green;
    logic [7:0] r_blue;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_blank;
    logic       r_tick;

    logic        w_pix_en;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_vis;
    logic        w_hs_act;
    logic        w_vs_act;
    logic [10:0] w_h_ext;
    logic [10:0] w_v_ext;

    assign w_pix_en = (r_div == c_DIV_LAST);
    assign w_h_wrap = (r_h_cnt == c_H_LAST);
    assign w_v_wrap = (r_v_cnt == c_V_LAST);
    assign w_h_ext  = {1'b0, r_h_cnt};
    assign w_v_ext  = {1'b0, r_v_cnt};
    assign w_vis    = (w_h_ext < c_H_VIS) && (w_v_ext < c_V_VIS);
    assign w_hs_act = (w_h_ext >= c_HS_BEG) && (w_h_ext < c_HS_END);
    assign w_vs_act = (w_v_ext >= c_VS_BEG) && (w_v_ext < c_VS_END);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div   <= 3'd0;
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
            r_red   <= 8'd0;
            r_green <= 8'd0;
            r_blue  <= 8'd0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_blank <= 1'b1;
            r_tick  <= 1'b0;
        end else begin
            r_div  <= w_pix_en ? 3'd0 : r_div + 3'd1;
            // Counters are about to become (0, V_VISIBLE): start of vertical blank
            r_tick <= w_pix_en && w_h_wrap && (r_v_cnt == c_V_TICK);
            if (w_pix_en) begin
                r_h_cnt <= w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
                if (w_h_wrap) begin
                    r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
                end
                r_blank <= ~w_vis;
                r_red   <= w_vis ? red_i   : 8'd0;
                r_green <= w_vis ? green_i : 8'd0;
                r_blue  <= w_vis ? blue_i  : 8'd0;
                r_hsync <= ~w_hs_act;
                r_vsync <= ~w_vs_act;
            end
        end
    end

    assign draw_xpos_o  = r_h_cnt;
    assign draw_ypos_o  = r_v_cnt;
    assign red_o        = r_red;
    assign green_o      = r_green;
    assign blue_o       = r_blue;
    assign hsync_o      = r_hsync;
    assign vsync_o      = r_vsync;
    assign blank_o      = r_blank;
    assign pix_en_o     = w_pix_en;
    assign frame_tick_o = r_tick;

endmodule
`default_nettype wire
